// File: rtl/cla_seq_controller_if.sv
// cla_seq_controller_if: bundles the request/result handshake and the shared
// 4-bit adder connection of cla_seq_controller.
//   slave  : controller side (takes start/operands/adder result, drives status,
//            result and adder operands)
//   master : requester/adder side (mirror of slave)
// Signals:
//   start, A, B, Cin, sub      request and operands
//   busy, done, F, Cout        status and result
//   add_A, add_B, add_Cin      nibble operands to the shared adder
//   add_F, add_Cout            combinational result of the shared adder
interface cla_seq_controller_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] F;
    logic             Cout;
    logic [3:0]       add_A;
    logic [3:0]       add_B;
    logic             add_Cin;
    logic [3:0]       add_F;
    logic             add_Cout;

    modport slave (
        input  start, A, B, Cin, sub, add_F, add_Cout,
        output busy, done, F, Cout, add_A, add_B, add_Cin
    );

    modport master (
        output start, A, B, Cin, sub, add_F, add_Cout,
        input  busy, done, F, Cout, add_A, add_B, add_Cin
    );
endinterface

// File: rtl/cla_seq_controller.sv
// cla_seq_controller: performs a WIDTH-bit addition on one shared 4-bit
// carry-lookahead adder, one nibble per clock, least significant nibble first.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  cla_seq_controller_if.slave (request, result, shared adder link)
// Latency from accepted start to done is WIDTH/4 cycles; F/Cout are held from
// done until the next accepted start.
// Optional feature: define CLA_SEQ_SUB_EN to honour bus.sub (A - B via ~B and
// an initial carry of 1). Without it, sub is ignored and no logic is built.
module cla_seq_controller #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_seq_controller_if.slave   bus
);
    localparam int unsigned STEPS = WIDTH / 4;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if ((WIDTH % 4) != 0 || WIDTH == 0) begin : g_width_check
        $error("cla_seq_controller: WIDTH must be a non-zero multiple of 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  op_a_q;
    logic [WIDTH-1:0]  op_b_q;
    logic              carry_q;
    logic [WIDTH-1:0]  f_q;
    logic              cout_q;

    logic              busy;
    logic              done;
    logic [3:0]        add_a;
    logic [3:0]        add_b;
    logic              add_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                busy    = 1'b1;
                add_a   = op_a_q[4*cnt_q +: 4];
                add_b   = op_b_q[4*cnt_q +: 4];
                add_cin = carry_q;
                if (cnt_q == LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath: operands latch only in idle, so a start seen in RUN/DONE has
    // no effect. F is written one nibble per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            f_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        cnt_q  <= '0;
                        op_a_q <= bus.A;
`ifdef CLA_SEQ_SUB_EN
                        // Two's-complement subtract: A + ~B + 1; Cout=1 means no borrow.
                        op_b_q  <= bus.sub ? ~bus.B : bus.B;
                        carry_q <= bus.sub ? 1'b1 : bus.Cin;
`else
                        op_b_q  <= bus.B;
                        carry_q <= bus.Cin;
`endif
                    end
                end
                StRun: begin
                    f_q[4*cnt_q +: 4] <= bus.add_F;
                    carry_q           <= bus.add_Cout;
                    cnt_q             <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cout_q <= bus.add_Cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.F       = f_q;
    assign bus.Cout    = cout_q;
    assign bus.add_A   = add_a;
    assign bus.add_B   = add_b;
    assign bus.add_Cin = add_cin;
endmodule

// File: tb/tb_cla_seq_controller.sv
// tb_cla_seq_controller: directed self-checking bench for cla_seq_controller
// (WIDTH=16). The bench models the shared 4-bit adder combinationally and
// compares results against hand-computed constants.
module tb_cla_seq_controller;
    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cla_seq_controller_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_controller #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared 4-bit adder.
    always_comb begin
        {bus.add_Cout, bus.add_F} = {1'b0, bus.add_A} + {1'b0, bus.add_B} + {4'h0, bus.add_Cin};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a start pulse; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic s);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.Cin   = cin;
        bus.sub   = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic s, input logic repulse,
                          input logic [15:0] exp_f, input logic exp_cout,
                          input logic [3:0] exp_cin_mask);
        int       nb;
        logic     got_done;
        logic [3:0] mask;
        nb       = 0;
        got_done = 1'b0;
        mask     = 4'h0;
        start_op(a, b, cin, s);
        check_eq({tag, "_addA0"}, {28'h0, bus.add_A}, {28'h0, a[3:0]});
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.done) begin
                got_done = 1'b1;
                check_eq({tag, "_busy_at_done"}, {31'h0, bus.busy}, 32'h0);
            end else if (bus.busy) begin
                if (nb < 4) mask[nb] = bus.add_Cin;
                nb++;
            end
            if (repulse && i == 1) begin
                bus.start = 1'b1;
                bus.A     = 16'hFFFF;
                bus.B     = 16'hFFFF;
            end
            if (repulse && i == 2) bus.start = 1'b0;
        end
        check_eq({tag, "_done_seen"}, {31'h0, got_done}, 32'h1);
        check_eq({tag, "_busy_cycles"}, nb, 32'd4);
        check_eq({tag, "_F"}, {16'h0, bus.F}, {16'h0, exp_f});
        check_eq({tag, "_Cout"}, {31'h0, bus.Cout}, {31'h0, exp_cout});
        check_eq({tag, "_cin_mask"}, {28'h0, mask}, {28'h0, exp_cin_mask});
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, {31'h0, bus.done}, 32'h0);
        check_eq({tag, "_idle_busy"}, {31'h0, bus.busy}, 32'h0);
        check_eq({tag, "_idle_addA"}, {28'h0, bus.add_A}, 32'h0);
        check_eq({tag, "_F_held"}, {16'h0, bus.F}, {16'h0, exp_f});
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Cin   = 1'b0;
        bus.sub   = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_F", {16'h0, bus.F}, 32'h0);
        check_eq("rst_Cout", {31'h0, bus.Cout}, 32'h0);
        check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
        check_eq("rst_done", {31'h0, bus.done}, 32'h0);
        check_eq("rst_addCin", {31'h0, bus.add_Cin}, 32'h0);
        rst = 1'b0;

        run_op("t2", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 4'b0110);
        run_op("t3", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b1110);
        run_op("t4", 16'h8888, 16'h8888, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b1, 4'b1111);
        run_op("t5", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 4'b0000);

        // Async reset mid-idle: result registers clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        check_eq("rst_idle_F", {16'h0, bus.F}, 32'h0);
        check_eq("rst_idle_Cout", {31'h0, bus.Cout}, 32'h0);
        rst = 1'b0;

        // Put a nonzero result in F, then reset mid-RUN of the next operation.
        run_op("t1a", 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, 16'h3334, 1'b0, 4'b0001);
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("mid_run_busy", {31'h0, bus.busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_run_busy", {31'h0, bus.busy}, 32'h0);
        check_eq("rst_run_done", {31'h0, bus.done}, 32'h0);
        check_eq("rst_run_F", {16'h0, bus.F}, 32'h0);
        check_eq("rst_run_Cout", {31'h0, bus.Cout}, 32'h0);
        check_eq("rst_run_addA", {28'h0, bus.add_A}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("t1b", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, 16'h1010, 1'b0, 4'b1010);

`ifdef CLA_SEQ_SUB_EN
        run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 4'b0001);
        run_op("t6b", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 4'b1111);
`else
        run_op("t6n", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'h000C, 1'b0, 4'b0000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end
endmodule
